// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//
// Purpose:
//   MIPS instruction decode stage with a small decoded-instruction queue.
//   Each offered 32-bit word is decoded combinationally into its fields,
//   register class and write-back register. The result is written into a
//   DEPTH-entry FIFO on push. All head outputs come from the entry at the
//   read pointer, so results appear one cycle after the push.
//
// Parameters:
//   XLEN  - width of the extended immediate (32 or 64)
//   DEPTH - queue depth (power of two, 2..16)
//
// Ports:
//   clk, rst_n    - clock (rising edge), async active-low reset
//   flush         - synchronous queue clear; discards same-cycle push/pop
//   in_valid      - upstream handshake; in_ready is registered-occupancy based
//   in_ready      - upstream handshake; independent of out_ready
//   instruction   - raw 32-bit MIPS word
//   out_valid     - downstream handshake for the head entry
//   out_ready     - downstream handshake for the head entry
//   opcode/r1/r2/r3/funct/jump - raw fields of the head instruction
//   imm_ext       - zero- or sign-extended immediate of the head
//   itype         - 0=R, 1=I, 2=J
//   dest          - write-back register of the head
//   count         - number of occupied entries
//
// Optional feature (macro INSTR_DECODE_PC_EN):
//   adds pc_in (captured at push) and pc_out (PC of the head entry).
// ---------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 opcode,
    output logic [4:0]                 r1,
    output logic [4:0]                 r2,
    output logic [4:0]                 r3,
    output logic [5:0]                 funct,
    output logic [XLEN-1:0]            imm_ext,
    output logic [25:0]                jump,
    output logic [1:0]                 itype,
    output logic [4:0]                 dest,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef INSTR_DECODE_PC_EN
    ,
    input  logic [31:0]                pc_in,
    output logic [31:0]                pc_out
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]      opcode;
        logic [4:0]      r1;
        logic [4:0]      r2;
        logic [4:0]      r3;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm;
        logic [25:0]     jump;
        logic [1:0]      itype;
        logic [4:0]      dest;
`ifdef INSTR_DECODE_PC_EN
        logic [31:0]     pc;
`endif
    } entry_t;

    entry_t                 w_dec;
    entry_t                 w_head;
    entry_t                 r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_init;
    logic                   w_push;
    logic                   w_pop;
    logic signed [15:0]     w_imm16;
    logic signed [XLEN-1:0] w_imm_sx;

    // ---- decode (combinational on the offered word) ----
    assign w_imm16  = signed'(instruction[15:0]);
    assign w_imm_sx = XLEN'(w_imm16);

    always_comb begin
        w_dec        = '0;
        w_dec.opcode = instruction[31:26];
        w_dec.r1     = instruction[25:21];
        w_dec.r2     = instruction[20:16];
        w_dec.r3     = instruction[15:11];
        w_dec.funct  = instruction[5:0];
        w_dec.jump   = instruction[25:0];
        case (instruction[31:26])
            6'd0: begin
                w_dec.itype = 2'd0;
                w_dec.dest  = instruction[15:11];
            end
            6'd2: begin
                w_dec.itype = 2'd2;
                w_dec.dest  = 5'd0;
            end
            6'd3: begin
                // JAL links into $ra
                w_dec.itype = 2'd2;
                w_dec.dest  = 5'd31;
            end
            default: begin
                w_dec.itype = 2'd1;
                w_dec.dest  = instruction[20:16];
            end
        endcase
        // ANDI/ORI/XORI use a logical (zero-extended) immediate
        if (instruction[31:26] inside {6'h0C, 6'h0D, 6'h0E})
            w_dec.imm = XLEN'(instruction[15:0]);
        else
            w_dec.imm = w_imm_sx;
`ifdef INSTR_DECODE_PC_EN
        w_dec.pc     = pc_in;
`endif
    end

    // ---- queue control ----
    // r_init holds in_ready low until the first edge after reset release.
    assign in_ready  = r_init && (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_init   <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                // Pointers wrap naturally because DEPTH is a power of two.
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // ---- queue storage ----
    // Storage is cleared by reset so the head outputs read zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end
    end

    // ---- head outputs ----
    assign w_head  = r_mem[r_rd_ptr];
    assign opcode  = w_head.opcode;
    assign r1      = w_head.r1;
    assign r2      = w_head.r2;
    assign r3      = w_head.r3;
    assign funct   = w_head.funct;
    assign imm_ext = w_head.imm;
    assign jump    = w_head.jump;
    assign itype   = w_head.itype;
    assign dest    = w_head.dest;
    assign count   = r_count;
`ifdef INSTR_DECODE_PC_EN
    assign pc_out  = w_head.pc;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_decode_stage
//
// Self-checking bench for instr_decode_stage (XLEN=64, DEPTH=4). A queue of
// raw instruction words models the FIFO; expected head fields are decoded
// from the word at the model's head with plain arithmetic. Directed vectors
// are followed by a randomized push/pop/flush phase.
// ---------------------------------------------------------------------------
module tb_instr_decode_stage;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      opcode;
    logic [4:0]      r1, r2, r3;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_ext;
    logic [25:0]     jump;
    logic [1:0]      itype;
    logic [4:0]      dest;
    logic [CW-1:0]   count;
`ifdef INSTR_DECODE_PC_EN
    logic [31:0]     pc_in;
    logic [31:0]     pc_out;
`endif

    instr_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instruction(instruction),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .r1         (r1),
        .r2         (r2),
        .r3         (r3),
        .funct      (funct),
        .imm_ext    (imm_ext),
        .jump       (jump),
        .itype      (itype),
        .dest       (dest),
        .count      (count)
`ifdef INSTR_DECODE_PC_EN
        ,
        .pc_in      (pc_in),
        .pc_out     (pc_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    item_t q[$];
    bit    m_init;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Expected sign/zero extended immediate, computed as an integer value.
    function automatic logic [63:0] ref_imm(input logic [31:0] w);
        longint v;
        int unsigned op;
        op = w >> 26;
        v  = longint'(w & 32'hFFFF);
        if (!(op >= 12 && op <= 14) && v >= 32768) v = v - 65536;
        return 64'(v);
    endfunction

    task automatic check_outputs();
        int unsigned w, op, exp_cls, exp_wb;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(m_init && q.size() != DEPTH));
        if (q.size() != 0) begin
            w  = q[0].instr;
            op = w >> 26;
            if (op == 0)      begin exp_cls = 0; exp_wb = (w >> 11) % 32; end
            else if (op == 2) begin exp_cls = 2; exp_wb = 0;              end
            else if (op == 3) begin exp_cls = 2; exp_wb = 31;             end
            else              begin exp_cls = 1; exp_wb = (w >> 16) % 32; end
            chk("opcode", 64'(opcode), 64'(op));
            chk("r1", 64'(r1), 64'((w >> 21) % 32));
            chk("r2", 64'(r2), 64'((w >> 16) % 32));
            chk("r3", 64'(r3), 64'((w >> 11) % 32));
            chk("funct", 64'(funct), 64'(w % 64));
            chk("imm_ext", imm_ext, ref_imm(w));
            chk("jump", 64'(jump), 64'(w % 32'h0400_0000));
            chk("itype", 64'(itype), 64'(exp_cls));
            chk("dest", 64'(dest), 64'(exp_wb));
`ifdef INSTR_DECODE_PC_EN
            chk("pc_out", 64'(pc_out), 64'(q[0].pc));
`endif
        end
    endtask

    // Drive one cycle from a negedge, update the model at the posedge, check at the next negedge.
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                         input logic fl, input logic [31:0] pc);
        bit    rdy, vld;
        item_t it;
        in_valid    = iv;
        instruction = ins;
        out_ready   = ordy;
        flush       = fl;
`ifdef INSTR_DECODE_PC_EN
        pc_in       = pc;
`endif
        @(posedge clk);
        rdy = m_init && (q.size() != DEPTH);
        vld = (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (vld && ordy) void'(q.pop_front());
            if (iv && rdy) begin
                it.instr = ins;
                it.pc    = pc;
                q.push_back(it);
            end
        end
        m_init = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  ops [10];
        ops = '{6'd0, 6'd2, 6'd3, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04};
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = '0;
`ifdef INSTR_DECODE_PC_EN
        pc_in = '0;
`endif
        m_init = 1'b0;

        // Reset state before any clock edge
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_imm", imm_ext, 64'd0);
        chk("rst_dest", 64'(dest), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", 64'(in_ready), 64'd0);

        // First edge after release: in_ready rises, the offered word is not taken
        cycle(1'b1, 32'h0085_1820, 1'b0, 1'b0, 32'h100);
        chk("rel_in_ready_high", 64'(in_ready), 64'd1);

        // R-type add $3,$4,$5
        cycle(1'b1, 32'h0085_1820, 1'b0, 1'b0, 32'h104);
        chk("r_out_valid", 64'(out_valid), 64'd1);
        chk("r_itype", 64'(itype), 64'd0);
        chk("r_r1", 64'(r1), 64'd4);
        chk("r_r2", 64'(r2), 64'd5);
        chk("r_r3", 64'(r3), 64'd3);
        chk("r_dest", 64'(dest), 64'd3);
        chk("r_funct", 64'(funct), 64'h20);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Immediate extension
        cycle(1'b1, 32'h2008_FFFF, 1'b0, 1'b0, 32'h200);
        chk("addi_imm", imm_ext, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_itype", 64'(itype), 64'd1);
        chk("addi_dest", 64'(dest), 64'd8);
        cycle(1'b1, 32'h3408_FFFF, 1'b1, 1'b0, 32'h204);
        chk("ori_imm", imm_ext, 64'h0000_0000_0000_FFFF);

        // Jumps
        cycle(1'b1, 32'h0C00_0010, 1'b1, 1'b0, 32'h208);
        chk("jal_itype", 64'(itype), 64'd2);
        chk("jal_dest", 64'(dest), 64'd31);
        chk("jal_jump", 64'(jump), 64'h10);
        cycle(1'b1, 32'h0800_0010, 1'b1, 1'b0, 32'h20C);
        chk("j_dest", 64'(dest), 64'd0);
        chk("j_itype", 64'(itype), 64'd2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Fill to full, then stream across pointer wrap
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_instr(), 1'b0, 1'b0, $urandom);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle(1'b1, rand_instr(), 1'b1, 1'b0, $urandom);
            chk("stream_count", 64'(count), 64'(DEPTH - 1));
        end
        while (q.size() != 0) cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Flush with a simultaneous push
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_instr(), 1'b0, 1'b0, $urandom);
        chk("pre_flush_count", 64'(count), 64'd3);
        cycle(1'b1, rand_instr(), 1'b1, 1'b1, 32'h0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("flush_lost", 64'(count), 64'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) cycle(1'b1, rand_instr(), 1'b0, 1'b0, $urandom);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_opcode", 64'(opcode), 64'd0);
        q.delete();
        m_init = 1'b0;
        #1 rst_n = 1'b1;
        cycle(1'b1, rand_instr(), 1'b0, 1'b0, 32'h0);
        chk("arst_in_ready_back", 64'(in_ready), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the extended immediate; legal values are 32 and 64.
REQ-002 Parameter DEPTH, default 4, SHALL set the decoded-instruction queue depth; legal values are powers of two from 2 to 16.
REQ-003 Ports SHALL be as follows, one per line, with clock and reset first:
 clk  in  1  single clock, all state updates on the rising edge
 rst_n  in  1  reset, asynchronous assert, active-low
 flush  in  1  synchronous queue clear
 in_valid  in  1  instruction offered
 in_ready  out  1  queue can accept
 instruction  in  32  raw MIPS word
 out_valid  out  1  head entry valid
 out_ready  in  1  consumer takes head
 opcode  out  6  head instr[31:26]
 r1  out  5  head instr[25:21] (rs)
 r2  out  5  head instr[20:16] (rt)
 r3  out  5  head instr[15:11] (rd)
 funct  out  6  head instr[5:0]
 imm_ext  out  XLEN  head extended immediate
 jump  out  26  head instr[25:0]
 itype  out  2  head class: 0=R, 1=I, 2=J
 dest  out  5  head write-back register
 count  out  clog2(DEPTH+1)  occupied entries

Function
REQ-004 Decode SHALL be performed combinationally on `instruction` and the result stored in the queue at push; all outputs other than in_ready and count SHALL be driven from the head entry register.
REQ-005 Opcode 0 SHALL give itype=0 and dest=r3; opcode 2 SHALL give itype=2 and dest=0; opcode 3 (JAL) SHALL give itype=2 and dest=31; every other opcode SHALL give itype=1 and dest=r2.
REQ-006 imm_ext SHALL be instr[15:0] zero-extended to XLEN for opcodes 0x0C, 0x0D and 0x0E, and sign-extended to XLEN for all other opcodes.
REQ-007 A push SHALL occur when in_valid and in_ready are both 1, and a pop SHALL occur when out_valid and out_ready are both 1.
REQ-008 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready.
REQ-009 out_valid SHALL equal (count != 0).
REQ-010 Latency SHALL be one cycle: an instruction pushed at edge N SHALL be visible with out_valid=1 after edge N, provided the queue was empty.
REQ-011 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; when the queue is full, the push SHALL be blocked because in_ready=0.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 When flush=1, the next edge SHALL set count=0 and reset both pointers; any push or pop in that cycle SHALL be discarded.
REQ-015 Entry data in non-occupied slots SHALL be don't-care; only out_valid qualifies the head outputs.

Reset
REQ-016 While rst_n=0, count=0, the pointers=0, out_valid=0 and in_ready=0 SHALL hold immediately without waiting for a clock edge.
REQ-017 While rst_n=0, head outputs SHALL read as all zero.
REQ-018 in_ready SHALL rise after the first clock edge following rst_n deassertion.
REQ-019 A reset asserted mid-operation SHALL discard all queued entries.

Configuration
REQ-020 Macro INSTR_DECODE_PC_EN, when defined, SHALL add input pc_in[31:0] and output pc_out[31:0]; pc_in SHALL be captured at push and pc_out SHALL present the head entry's PC, with reset value 0.
REQ-021 When INSTR_DECODE_PC_EN is undefined, the pc ports and their storage SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-022 After reset release, push 0x00851820 -> itype=0, r1=4, r2=5, r3=3, dest=3, funct=0x20, out_valid=1 one cycle later.
REQ-023 Push 0x2008FFFF with XLEN=64 -> imm_ext=0xFFFFFFFFFFFFFFFF, itype=1, dest=8; push 0x3408FFFF -> imm_ext=0x000000000000FFFF.
REQ-024 Push 0x0C000010 -> itype=2, dest=31, jump=0x0000010; push 0x08000010 -> dest=0.
REQ-025 With out_ready=0, push DEPTH entries -> count=DEPTH and in_ready=0; then hold in_valid=1 with out_ready=1 for 2*DEPTH cycles -> entries emerge in order across pointer wrap and count stays constant.
REQ-026 With 3 entries queued, assert flush together with in_valid=1 -> count=0 and out_valid=0 next cycle, and the offered instruction is lost.
REQ-027 With 2 entries queued, pulse rst_n low between clock edges -> out_valid=0 and count=0 immediately.
